// File: rtl/nco_mc_pkg.sv
// Shared constants for the multichannel time-division NCO: pipeline latency,
// configuration-select encoding and channel-index width.
package nco_mc_pkg;

  localparam int LAT = 4;
  localparam int CHW = 3;

  typedef enum logic {
    SEL_INC = 1'b0,
    SEL_OFF = 1'b1
  } cfg_sel_e;

endpackage

// File: rtl/nco_sincos_lut.sv
// Registered quarter-wave sine ROM: entry i = round(A*sin(2*pi*i/2^PW)) for the
// first quadrant; 'peak' selects the full-scale value that the table itself cannot address.
module nco_sincos_lut #(
  parameter int PW  = 12,
  parameter int MPR = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic [PW-3:0]  addr,
  input  logic           peak,
  output logic [MPR-2:0] mag
);

  localparam int  DEPTH = 2 ** (PW - 2);
  localparam real AMP   = 2.0 ** (MPR - 1) - 1.0;
  localparam real PI    = 3.14159265358979323846;

  function automatic logic [MPR-2:0] entry(input int idx);
    real x;
    x = AMP * $sin(PI * real'(idx) / real'(2 * DEPTH)) + 0.5;
    return (MPR-1)'($rtoi(x));
  endfunction

  // NOTE: the ROM is constant wiring and is never reset; only the read register is.
  logic [MPR-2:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = entry(i);
  end

  // NOTE: clocked state always uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      mag <= '0;
    else if (clken) mag <= peak ? '1 : rom[addr];
  end

endmodule

// File: rtl/nco_mc_tdm.sv
// Time-multiplexed NCO: NCH phase accumulators share one sin/cos datapath,
// one channel per clken cycle, with shadowed configuration committed at frame start.
module nco_mc_tdm
  import nco_mc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int APR = 48,
  parameter int PW  = 12,
  parameter int MPR = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  cfg_we,
  input  logic [CHW-1:0]        cfg_ch,
  input  logic                  cfg_sel,
  input  logic [APR-1:0]        cfg_data,
  input  logic                  cfg_commit,
  input  logic                  sync_i,
  output logic signed [MPR-1:0] fsin_o,
  output logic signed [MPR-1:0] fcos_o,
  output logic [CHW-1:0]        ch_o,
  output logic                  out_valid
);

  localparam logic [PW-1:0] QTR = PW'(1) << (PW - 2);

  typedef struct packed {
    logic [PW-3:0] addr;
    logic          peak;
    logic          neg;
  } fold_t;

  // Quadrant fold: odd quadrants mirror the address, the upper half negates.
  function automatic fold_t fold(input logic [PW-1:0] ph_in);
    fold_t         f;
    logic [PW-3:0] a;
    a      = ph_in[PW-3:0];
    f.neg  = ph_in[PW-1];
    f.peak = ph_in[PW-2] && (a == '0);
    f.addr = ph_in[PW-2] ? -a : a;
    return f;
  endfunction

  logic [APR-1:0] acc       [NCH];
  logic [APR-1:0] inc       [NCH];
  logic [APR-1:0] inc_sh    [NCH];
  logic [APR-1:0] inc_sh_nx [NCH];
  logic [PW-1:0]  off       [NCH];
  logic [PW-1:0]  off_sh    [NCH];
  logic [PW-1:0]  off_sh_nx [NCH];

  logic [CHW-1:0] slot;
  logic           commit_pend, sync_pend;
  logic           frame, commit_now, sync_now;
  logic [APR-1:0] acc_s, inc_s;
  logic [PW-1:0]  off_s, ph;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    inc_sh_nx = inc_sh;
    off_sh_nx = off_sh;
    for (int k = 0; k < NCH; k++) begin
      if (cfg_we && cfg_ch == CHW'(k)) begin
        if (cfg_sel_e'(cfg_sel) == SEL_OFF) off_sh_nx[k] = cfg_data[PW-1:0];
        else                                inc_sh_nx[k] = cfg_data;
      end
    end
  end

  assign frame      = clken && (slot == '0);
  assign commit_now = frame && (commit_pend || cfg_commit);
  assign sync_now   = frame && (sync_pend || sync_i);

  // Commit and sync take effect before slot 0 is sampled, including same-cycle writes.
  always_comb begin
    acc_s = '0;
    inc_s = '0;
    off_s = '0;
    for (int k = 0; k < NCH; k++) begin
      if (slot == CHW'(k)) begin
        acc_s = acc[k];
        inc_s = inc[k];
        off_s = off[k];
      end
    end
    if (commit_now) begin
      inc_s = inc_sh_nx[0];
      off_s = off_sh_nx[0];
    end
    if (sync_now) acc_s = '0;
    ph = acc_s[APR-1 -: PW] + off_s;
  end

  // Shadows and request flags keep capturing while clken is low so no request is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        inc_sh[k] <= '0;
        off_sh[k] <= '0;
      end
      commit_pend <= 1'b0;
      sync_pend   <= 1'b0;
    end else begin
      inc_sh      <= inc_sh_nx;
      off_sh      <= off_sh_nx;
      commit_pend <= !commit_now && (commit_pend || cfg_commit);
      sync_pend   <= !sync_now && (sync_pend || sync_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc[k] <= '0;
        inc[k] <= '0;
        off[k] <= '0;
      end
    end else if (clken) begin
      slot <= (slot == CHW'(NCH - 1)) ? '0 : slot + 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (commit_now) begin
          inc[k] <= inc_sh_nx[k];
          off[k] <= off_sh_nx[k];
        end
        if (slot == CHW'(k)) acc[k] <= acc_s + inc_s;
        else if (sync_now)   acc[k] <= '0;
      end
    end
  end

  // Four clken stages: phase, fold, ROM read, sign/output.
  logic [PW-1:0]   ph1;
  logic [CHW-1:0]  ch1, ch2, ch3;
  fold_t           sf2, cf2;
  logic            sneg3, cneg3;
  logic [MPR-2:0]  smag3, cmag3;
  logic [LAT-2:0]  vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph1   <= '0;
      ch1   <= '0;
      ch2   <= '0;
      ch3   <= '0;
      sf2   <= '0;
      cf2   <= '0;
      sneg3 <= 1'b0;
      cneg3 <= 1'b0;
      vld   <= '0;
    end else if (clken) begin
      ph1   <= ph;
      ch1   <= slot;
      sf2   <= fold(ph1);
      cf2   <= fold(ph1 + QTR);
      ch2   <= ch1;
      sneg3 <= sf2.neg;
      cneg3 <= cf2.neg;
      ch3   <= ch2;
      vld   <= {vld[LAT-3:0], 1'b1};
    end
  end

  nco_sincos_lut #(.PW(PW), .MPR(MPR)) u_sin_lut (
    .clk   (clk),
    .reset (reset),
    .clken (clken),
    .addr  (sf2.addr),
    .peak  (sf2.peak),
    .mag   (smag3)
  );

  nco_sincos_lut #(.PW(PW), .MPR(MPR)) u_cos_lut (
    .clk   (clk),
    .reset (reset),
    .clken (clken),
    .addr  (cf2.addr),
    .peak  (cf2.peak),
    .mag   (cmag3)
  );

  logic signed [MPR-1:0] sval, cval;

  always_comb begin
    sval = $signed({1'b0, smag3});
    cval = $signed({1'b0, cmag3});
    if (sneg3) sval = -sval;
    if (cneg3) cval = -cval;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsin_o    <= '0;
      fcos_o    <= '0;
      ch_o      <= '0;
      out_valid <= 1'b0;
    end else if (clken) begin
      fsin_o    <= vld[LAT-2] ? sval : '0;
      fcos_o    <= vld[LAT-2] ? cval : '0;
      ch_o      <= vld[LAT-2] ? ch3 : '0;
      out_valid <= vld[LAT-2];
    end
  end

endmodule

// File: tb/tb_nco_mc_tdm.sv
// Self-checking bench for nco_mc_tdm: a behavioural model (real-valued sin/cos,
// integer accumulators, a latency queue) scores every cycle; directed steps pin key cases.
module tb_nco_mc_tdm;

  localparam int  NCH = 4;
  localparam int  APR = 48;
  localparam int  PW  = 12;
  localparam int  MPR = 16;
  localparam int  LAT = 4;
  localparam int  AMP = 32767;
  localparam real PI  = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  reset, clken, cfg_we, cfg_sel, cfg_commit, sync_i;
  logic [2:0]            cfg_ch;
  logic [APR-1:0]        cfg_data;
  logic signed [MPR-1:0] fsin, fcos, fsin1, fcos1;
  logic [2:0]            ch, ch1;
  logic                  vld, vld1;

  nco_mc_tdm #(.NCH(NCH), .APR(APR), .PW(PW), .MPR(MPR)) dut (
    .clk(clk), .reset(reset), .clken(clken), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .sync_i(sync_i),
    .fsin_o(fsin), .fcos_o(fcos), .ch_o(ch), .out_valid(vld)
  );

  nco_mc_tdm #(.NCH(1), .APR(APR), .PW(PW), .MPR(MPR)) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .sync_i(sync_i),
    .fsin_o(fsin1), .fcos_o(fcos1), .ch_o(ch1), .out_valid(vld1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int s;
    int c;
    int ch;
  } samp_t;

  logic [APR-1:0] m_acc [NCH];
  logic [APR-1:0] m_inc [NCH];
  logic [APR-1:0] m_inc_sh [NCH];
  int             m_off [NCH];
  int             m_off_sh [NCH];
  bit             m_cpend, m_spend;
  int             m_slot;
  samp_t          m_q [$];
  samp_t          m_exp;

  int tests = 0;
  int fails = 0;

  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic samp_t make(int ph, int c);
    samp_t r;
    real   ang;
    ang  = 2.0 * PI * real'(ph) / real'(1 << PW);
    r.v  = 1'b1;
    r.s  = rnd(real'(AMP) * $sin(ang));
    r.c  = rnd(real'(AMP) * $cos(ang));
    r.ch = c;
    return r;
  endfunction

  function automatic logic [APR-1:0] rand48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[APR-1:0];
  endfunction

  task automatic model_reset();
    samp_t z;
    z = '{v: 1'b0, s: 0, c: 0, ch: 0};
    for (int k = 0; k < NCH; k++) begin
      m_acc[k]    = '0;
      m_inc[k]    = '0;
      m_inc_sh[k] = '0;
      m_off[k]    = 0;
      m_off_sh[k] = 0;
    end
    m_cpend = 1'b0;
    m_spend = 1'b0;
    m_slot  = 0;
    m_q.delete();
    repeat (LAT - 1) m_q.push_back(z);
    m_exp = z;
  endtask

  // One rising edge of the reference: apply config rules, then issue the current slot.
  task automatic model_edge();
    bit do_c, do_s;
    int ph, idx, s;
    do_c = clken && (m_slot == 0) && (m_cpend || cfg_commit);
    do_s = clken && (m_slot == 0) && (m_spend || sync_i);
    idx  = int'(cfg_ch);
    if (cfg_we && idx < NCH) begin
      if (cfg_sel) m_off_sh[idx] = int'(cfg_data % (1 << PW));
      else         m_inc_sh[idx] = cfg_data;
    end
    m_cpend = !do_c && (m_cpend || cfg_commit);
    m_spend = !do_s && (m_spend || sync_i);
    if (clken) begin
      s = m_slot;
      if (do_c) begin
        for (int k = 0; k < NCH; k++) begin
          m_inc[k] = m_inc_sh[k];
          m_off[k] = m_off_sh[k];
        end
      end
      if (do_s) begin
        for (int k = 0; k < NCH; k++) m_acc[k] = '0;
      end
      ph       = (int'(m_acc[s] >> (APR - PW)) + m_off[s]) % (1 << PW);
      m_acc[s] = m_acc[s] + m_inc[s];
      m_q.push_back(make(ph, s));
      m_exp  = m_q.pop_front();
      m_slot = (m_slot + 1) % NCH;
    end
  endtask

  task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check("fsin", fsin, m_exp.s);
    check("fcos", fcos, m_exp.c);
    check("ch_o", ch, m_exp.ch);
    check("out_valid", vld, m_exp.v);
  endtask

  task automatic idle();
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_sel    = 1'b0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    sync_i     = 1'b0;
  endtask

  task automatic cfg_write(int c, bit sel, logic [APR-1:0] data, bit commit);
    cfg_we     = 1'b1;
    cfg_ch     = 3'(c);
    cfg_sel    = sel;
    cfg_data   = data;
    cfg_commit = commit;
    tick();
    idle();
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  int sin1_exp [4];
  int cos1_exp [4];

  initial begin
    sin1_exp = '{0, 32767, 0, -32767};
    cos1_exp = '{32767, 0, -32767, 0};
    reset = 1'b1;
    clken = 1'b0;
    idle();
    model_reset();

    // Reset state on both instances.
    tick();
    tick();
    check("rst_sin1", fsin1, 0);
    check("rst_cos1", fcos1, 0);
    check("rst_ch1", ch1, 0);
    check("rst_valid1", vld1, 0);

    // Quarter-turn increment on channel 0, written and committed in the same cycle.
    @(negedge clk);
    reset = 1'b0;
    clken = 1'b1;
    cfg_write(0, 1'b0, 48'h1 << (APR - 2), 1'b1);
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      check("nch1_sin", fsin1, sin1_exp[k % 4]);
      check("nch1_cos", fcos1, cos1_exp[k % 4]);
      check("nch1_valid", vld1, 1);
    end

    // Distinct random increments and offsets on all channels, committed mid-frame.
    for (int c = 0; c < NCH; c++) begin
      cfg_write(c, 1'b0, rand48(), 1'b0);
      cfg_write(c, 1'b1, APR'($urandom_range(0, (1 << PW) - 1)), 1'b0);
    end
    pulse_commit();
    repeat (24) tick();

    // Shadow-only write leaves outputs alone until a commit reaches a frame start.
    cfg_write(1, 1'b0, rand48(), 1'b0);
    repeat (12) tick();
    pulse_commit();
    repeat (12) tick();

    // Zero increment with quarter offset, committed together with a sync.
    cfg_write(2, 1'b0, '0, 1'b0);
    cfg_write(2, 1'b1, APR'(1 << (PW - 2)), 1'b0);
    cfg_commit = 1'b1;
    sync_i     = 1'b1;
    tick();
    idle();
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_exp.ch == 2 && m_exp.v) begin
        check("off_sin", fsin, 32767);
        check("off_cos", fcos, 0);
      end
    end

    // Sync requested mid-frame: the whole next frame samples acc = 0.
    for (int c = 0; c < NCH; c++) cfg_write(c, 1'b1, '0, 1'b0);
    pulse_commit();
    repeat (8) tick();
    for (int i = 0; i < 8 && m_slot != 2; i++) tick();
    check("sync_align", m_slot, 2);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    repeat (4) tick();
    for (int j = 0; j < NCH; j++) begin
      tick();
      check("sync_sin", fsin, 0);
      check("sync_cos", fcos, 32767);
      check("sync_ch", ch, j);
    end

    // Clock-enable hold, then reset in the middle of operation.
    clken = 1'b0;
    repeat (5) tick();
    clken = 1'b1;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_sin", fsin, 0);
    check("mid_rst_cos", fcos, 0);
    check("mid_rst_ch", ch, 0);
    check("mid_rst_valid", vld, 0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      check("refill_low", vld, 0);
    end
    tick();
    check("refill_high", vld, 1);

    // Randomized traffic, including writes to channels beyond NCH.
    for (int i = 0; i < 300; i++) begin
      clken      = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_ch     = 3'($urandom_range(0, 7));
      cfg_sel    = 1'($urandom_range(0, 1));
      cfg_data   = rand48();
      cfg_commit = clken && ($urandom_range(0, 9) == 0);
      sync_i     = clken && ($urandom_range(0, 19) == 0);
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nco_mc_tdm.md
NCO_MC_TDM -- requirements
Module: nco_mc_tdm

Interface
REQ-001 SHALL have parameter NCH, default 4, number of time-multiplexed channels (1..8).
REQ-002 SHALL have parameter APR, default 48, phase-accumulator width.
REQ-003 SHALL have parameter PW, default 12, truncated phase width (LUT address width + 2).
REQ-004 SHALL have parameter MPR, default 16, signed output width.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port clken  in  1  clock enable; low freezes all state except the config shadow registers.
REQ-008 SHALL have port cfg_we  in  1  shadow-register write strobe.
REQ-009 SHALL have port cfg_ch  in  3  target channel; writes with cfg_ch>=NCH are ignored.
REQ-010 SHALL have port cfg_sel  in  1  0=phase increment, 1=phase offset.
REQ-011 SHALL have port cfg_data  in  APR  increment value, or offset in bits [PW-1:0].
REQ-012 SHALL have port cfg_commit  in  1  request to copy all shadows to active at the next frame start.
REQ-013 SHALL have port sync_i  in  1  request to clear all accumulators at the next frame start.
REQ-014 SHALL have port fsin_o  out  MPR  signed sine.
REQ-015 SHALL have port fcos_o  out  MPR  signed cosine.
REQ-016 SHALL have port ch_o  out  3  channel index of the current output sample.
REQ-017 SHALL have port out_valid  out  1  output sample valid.

Function
REQ-018 SHALL advance slot counter 0..NCH-1 by one per clken cycle and wrap to 0; slot 0 is the frame start.
REQ-019 SHALL, in slot ch, sample acc[ch] and then update acc[ch] <= acc[ch]+inc[ch] modulo 2^APR (wrap, no saturation).
REQ-020 SHALL compute phase p = (acc[ch][APR-1:APR-PW] + off[ch]) mod 2^PW using the pre-update acc value.
REQ-021 SHALL output sin = round((2^(MPR-1)-1)*sin(2*pi*p/2^PW)) and cos likewise, via quarter-wave fold; no value equals -2^(MPR-1).
REQ-022 SHALL present a slot's fsin_o/fcos_o/ch_o exactly LAT=4 clken cycles after the slot is issued; clken low holds the outputs.
REQ-023 SHALL assert out_valid after the first LAT clken cycles following reset and keep it high; outputs are 0 while out_valid is low.
REQ-024 SHALL write cfg_data to the shadow on any clk edge with cfg_we=1, independent of clken.
REQ-025 SHALL latch cfg_commit into a pending flag; at the next clken frame start, copy all shadows to active before that slot is used, then clear the flag.
REQ-026 SHALL use the new shadow value when cfg_we and cfg_commit occur in the same cycle.
REQ-027 SHALL latch sync_i as pending; at the next frame start, zero all accumulators so slot-0 samples use acc=0, then clear the flag.
REQ-028 SHALL apply the new increments to the zeroed accumulators when sync and commit are pending at the same frame start.

Reset
REQ-029 SHALL on reset clear acc, inc, off, shadows, pending flags, slot counter, and pipeline; outputs fsin_o=0, fcos_o=0, ch_o=0, out_valid=0.
REQ-030 SHALL on reset mid-operation discard in-flight samples and re-run the REQ-023 fill.

Structure
REQ-031 SHALL place LAT, the cfg_sel encodings (SEL_INC/SEL_OFF), and the channel-index width in shared package nco_mc_pkg.
REQ-032 SHALL implement the registered quarter-wave ROM (2^(PW-2) entries, MPR-1 bits, 1-cycle latency with clken) as sub-module nco_sincos_lut, instantiated once for sin and cos.

Verification
REQ-033 SHALL check NCH=1, inc=2^(APR-2), off=0, commit -> fsin_o sequence 0,32767,0,-32767 repeating; fcos_o sequence 32767,0,-32767,0.
REQ-034 SHALL check NCH=4 with distinct incs -> ch_o cycles 0,1,2,3 and each channel's phase advances by its own inc only.
REQ-035 SHALL check a write of inc without commit -> output unchanged; after commit, the change takes effect exactly at the next slot-0 sample +1 frame.
REQ-036 SHALL check offset=2^(PW-2) with inc=0 -> fsin_o=32767, fcos_o=0 constant.
REQ-037 SHALL check sync_i mid-frame -> at the next frame, channel samples are sin=0 and cos=32767 (off=0).
REQ-038 SHALL check clken held low for 5 cycles, then reset asserted mid-run -> outputs frozen during the hold, then all zero with out_valid=0, valid restored after LAT enabled cycles.
